// File: rtl/frac_search_pkg.sv
// Shared types and defaults for the fractional-search pixel front end.
package frac_search_pkg;

  localparam int unsigned FILT_BYTES_DEF = 16;
  localparam int unsigned REF_BYTES_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILT = 2'd1,
    ST_REF  = 2'd2,
    ST_HOLD = 2'd3
  } ldr_state_e;

  // Index width that stays legal for single-entry windows.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_out_reg.sv
// Single-entry output holding register with valid/ready handshake.
module pix_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free_c
);

  // Free when empty or being drained this cycle, so a load never overwrites.
  assign free_c = !valid || ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pix_stream_loader.sv
// Assembles a host byte stream into filter/reference pixel windows for the search engine.
module pix_stream_loader
  import frac_search_pkg::*;
#(
  parameter int unsigned FILT_BYTES = FILT_BYTES_DEF,
  parameter int unsigned REF_BYTES  = REF_BYTES_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  output logic                    in_ready,
  output logic [8*FILT_BYTES-1:0] filter_pix,
  output logic [8*REF_BYTES-1:0]  ref_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             blk_cnt,
  output logic                    sync_err
);

  localparam int unsigned FILT_W = 8 * FILT_BYTES;
  localparam int unsigned REF_W  = 8 * REF_BYTES;
  localparam int unsigned BLK_W  = FILT_W + REF_W;
  localparam int unsigned FI_W   = clog2_min1(FILT_BYTES);
  localparam int unsigned RI_W   = clog2_min1(REF_BYTES);
  localparam int unsigned IDX_W  = (FI_W > RI_W) ? FI_W : RI_W;

  ldr_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       filt_asm [FILT_BYTES];
  logic [7:0]       ref_asm  [REF_BYTES];
  logic             accept;
  logic             filt_last, ref_last;
  logic             load_c;
  logic             out_free_c;
  logic [BLK_W-1:0] blk_c;
  logic [BLK_W-1:0] blk_q;

  assign accept    = in_valid && in_ready;
  assign filt_last = (idx == IDX_W'(FILT_BYTES - 1));
  assign ref_last  = (idx == IDX_W'(REF_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, transfer strobe and block image (last ref byte merged in flight).
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    blk_c     = '0;
    for (int k = 0; k < int'(FILT_BYTES); k++) blk_c[8*k +: 8] = filt_asm[k];
    for (int k = 0; k < int'(REF_BYTES); k++) begin
      if (state == ST_REF && accept && !in_sop && idx[RI_W-1:0] == RI_W'(k))
        blk_c[FILT_W + 8*k +: 8] = in_data;
      else
        blk_c[FILT_W + 8*k +: 8] = ref_asm[k];
    end
    case (state)
      ST_IDLE: if (accept && in_sop) state_nxt = ST_FILT;
      ST_FILT: if (accept && !in_sop && filt_last) state_nxt = ST_REF;
      ST_REF: begin
        if (accept) begin
          if (in_sop) begin
            state_nxt = ST_FILT;
          end else if (ref_last) begin
            if (out_free_c) begin
              load_c    = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (out_free_c) begin
          load_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      in_ready <= 1'b1;
      sync_err <= 1'b0;
      blk_cnt  <= '0;
      for (int k = 0; k < int'(FILT_BYTES); k++) filt_asm[k] <= '0;
      for (int k = 0; k < int'(REF_BYTES); k++) ref_asm[k] <= '0;
    end else begin
      in_ready <= (state_nxt != ST_HOLD);
      if (out_valid && out_ready) blk_cnt <= blk_cnt + 16'd1;
      if (accept) begin
        // A start-of-packet always restarts the block; mid-block it is a sync error.
        if (in_sop) begin
          filt_asm[0] <= in_data;
          idx         <= IDX_W'(1);
          if (state != ST_IDLE) sync_err <= 1'b1;
        end else begin
          case (state)
            ST_IDLE: sync_err <= 1'b1;
            ST_FILT: begin
              filt_asm[idx[FI_W-1:0]] <= in_data;
              idx <= filt_last ? '0 : idx + IDX_W'(1);
            end
            ST_REF: begin
              ref_asm[idx[RI_W-1:0]] <= in_data;
              idx <= ref_last ? '0 : idx + IDX_W'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  pix_out_reg #(.W(BLK_W)) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load_c),
    .load_data (blk_c),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (blk_q),
    .free_c    (out_free_c)
  );

  assign filter_pix = blk_q[FILT_W-1:0];
  assign ref_pix    = blk_q[BLK_W-1:FILT_W];

endmodule

// File: doc/pix_stream_loader.md
PIX_STREAM_LOADER -- requirements
Module: pix_stream_loader

Interface
REQ-001 Parameters SHALL be: FILT_BYTES, default 16, filter window bytes; REF_BYTES, default 8, reference window bytes.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  8  pixel byte from host stream.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_sop  input  1  qualifies in_data as first byte of a block; valid only with in_valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 filter_pix  output  8*FILT_BYTES  assembled filter window to the search engine.
REQ-009 ref_pix  output  8*REF_BYTES  assembled reference window.
REQ-010 out_valid  output  1  filter_pix/ref_pix hold a complete block.
REQ-011 out_ready  input  1  search engine consumes the block.
REQ-012 blk_cnt  output  16  count of blocks delivered (out_valid&&out_ready).
REQ-013 sync_err  output  1  sticky flag: block restarted by in_sop before completion, or non-sop first byte.

Function
REQ-014 A byte SHALL be accepted only when in_valid && in_ready.
REQ-015 Accepted bytes SHALL fill the filter window first (FILT_BYTES bytes), then the reference window (REF_BYTES bytes); byte k of each window lands in bits [8k+7:8k].
REQ-016 The FSM SHALL have states IDLE, FILT, REF, HOLD.
REQ-017 IDLE: an accepted byte with in_sop=1 is stored as filter byte 0 and moves to FILT; an accepted byte with in_sop=0 is dropped and sets sync_err.
REQ-018 FILT: after filter byte FILT_BYTES-1 is accepted, move to REF with the byte index cleared.
REQ-019 REF: when reference byte REF_BYTES-1 is accepted, the assembled block SHALL transfer to the output register if it is empty or being drained that cycle (then go to IDLE), else go to HOLD.
REQ-020 HOLD: in_ready=0; transfer assembly to output on the cycle the output register is empty or drained, then go to IDLE.
REQ-021 in_ready SHALL be 1 in IDLE, FILT and REF, 0 in HOLD.
REQ-022 An accepted in_sop=1 byte in FILT or REF SHALL discard the partial block, restart at filter byte 0, and set sync_err.
REQ-023 out_valid SHALL rise the cycle after the transferring edge (latency 1 cycle from last ref byte when output is free); filter_pix/ref_pix SHALL remain stable while out_valid && !out_ready.
REQ-024 Output drain and new transfer in the same cycle SHALL leave out_valid=1 with the new block (no bubble).
REQ-025 blk_cnt SHALL increment by 1 per delivered block and wrap 16'hFFFF -> 0.
REQ-026 Back-to-back streaming at one byte per cycle SHALL sustain full throughput (FILT_BYTES+REF_BYTES cycles per block) while out_ready=1.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, byte index 0, out_valid=0, filter_pix=0, ref_pix=0, blk_cnt=0, sync_err=0; in_ready=1 after release.
REQ-028 Reset mid-block or with out_valid=1 SHALL discard all data; no block is delivered after release without a fresh in_sop.

Structure
REQ-029 FSM state encoding and default FILT_BYTES/REF_BYTES constants SHALL live in the shared frac_search package.
REQ-030 One sub-module, pix_out_reg (output holding register with valid/ready), SHALL be used; the rest is flat.

Verification
REQ-031 Reset, then stream 24 bytes 0x00..0x17 (sop on first), out_ready=1 -> out_valid one cycle after byte 0x17; filter_pix=0x0F0E..0100, ref_pix=0x17161514131211_10; blk_cnt=1.
REQ-032 Two blocks back-to-back, out_ready=0 -> in_ready drops after 48th byte (HOLD); raise out_ready -> first block delivered, second follows next cycle, blk_cnt=2.
REQ-033 sop at byte 10, then 24 bytes 0xA0..0xB7 -> sync_err=1; delivered filter_pix byte 0=0xA0, only one block.
REQ-034 First byte without sop (0x55) then valid block -> 0x55 dropped, sync_err=1, block intact.
REQ-035 Assert reset_n=0 at byte 20 of a block -> out_valid=0, blk_cnt=0; no output until a new sop block completes.
REQ-036 Preload blk_cnt path with 65536 blocks (or force) -> blk_cnt wraps to 0.
